// File: rtl/aclk_lcd_bus_if.sv
// aclk_lcd_bus_if: byte handshake from the display logic plus the HD44780 pin bundle
interface aclk_lcd_bus_if;
  logic [7:0] char_data;
  logic       char_cmd;
  logic       char_valid;
  logic       char_ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  modport master (
    output char_data, char_cmd, char_valid,
    input  char_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
  modport slave (
    input  char_data, char_cmd, char_valid,
    output char_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
endinterface

// File: rtl/aclk_lcd_bus_ctrl.sv
// aclk_lcd_bus_ctrl: write-only HD44780 bus sequencer with power-up wait and fixed init
module aclk_lcd_bus_ctrl #(
  parameter int PWRUP_CYC    = 750000,
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 12,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input logic clk,
  input logic reset,
  aclk_lcd_bus_if.slave bus
);
  localparam int M0 = PWRUP_CYC > CLR_WAIT_CYC ? PWRUP_CYC : CLR_WAIT_CYC;
  localparam int M1 = WAIT_CYC > EN_CYC ? WAIT_CYC : EN_CYC;
  localparam int M2 = M1 > SETUP_CYC ? M1 : SETUP_CYC;
  localparam int MX = M0 > M2 ? M0 : M2;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic done;
  logic clr;
  function automatic logic [7:0] rom(input logic [1:0] i);
    return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h06 : 8'h01;
  endfunction
  assign done = cnt == '0;
  // clear/home instructions need the long execution wait; RS/DB still hold the byte
  assign clr = !bus.lcd_rs && (bus.lcd_data == 8'h01 || bus.lcd_data == 8'h02);
  assign bus.lcd_rw = 1'b0;
  always_ff @(posedge clk)
    if (reset) begin
      st             <= PWRUP;
      cnt            <= CW'(PWRUP_CYC - 1);
      idx            <= '0;
      bus.lcd_en     <= 1'b0;
      bus.lcd_rs     <= 1'b0;
      bus.lcd_data   <= '0;
      bus.char_ready <= 1'b0;
      bus.init_done  <= 1'b0;
    end else begin
      if (!done) cnt <= cnt - 1'b1;
      case (st)
        PWRUP: if (done) begin
          st           <= SETUP;
          cnt          <= CW'(SETUP_CYC - 1);
          idx          <= '0;
          bus.lcd_rs   <= 1'b0;
          bus.lcd_data <= rom(2'd0);
        end
        SETUP: if (done) begin
          st         <= PULSE;
          cnt        <= CW'(EN_CYC - 1);
          bus.lcd_en <= 1'b1;
        end
        PULSE: if (done) begin
          st         <= HOLD;
          bus.lcd_en <= 1'b0;
        end
        HOLD: begin
          st  <= WAIT;
          cnt <= clr ? CW'(CLR_WAIT_CYC - 1) : CW'(WAIT_CYC - 1);
        end
        WAIT: if (done) begin
          if (bus.init_done || idx == 2'd3) begin
            st             <= IDLE;
            bus.char_ready <= 1'b1;
            bus.init_done  <= 1'b1;
          end else begin
            st           <= SETUP;
            cnt          <= CW'(SETUP_CYC - 1);
            idx          <= idx + 2'd1;
            bus.lcd_data <= rom(2'(idx + 2'd1));
          end
        end
        IDLE: if (bus.char_valid) begin
          st             <= SETUP;
          cnt            <= CW'(SETUP_CYC - 1);
          bus.char_ready <= 1'b0;
          bus.lcd_rs     <= !bus.char_cmd;
          bus.lcd_data   <= bus.char_data;
        end
        default: st <= PWRUP;
      endcase
    end
endmodule
